// File: rtl/pattern_detection_one_oh_one.sv
// Serial "101" detector: Moore FSM sampling datain each rising clk edge.
// Latency: pattern_detected is high for the cycle after the edge that samples the final '1'.
// Backpressure: none; one bit is consumed every clock, output is a one-cycle pulse.
module pattern_detection_one_oh_one #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       datain,
    output logic       pattern_detected,
    output logic [2:0] temp
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3
    } state_t;

    // Held as a plain 3-bit vector so the unused codes 4..7 are representable
    // and recover through the default branch below.
    logic [2:0] state;
    logic [2:0] next_state;

    // State register; reset drops straight back to idle without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; after a match the trailing '1' is reused only when overlapping.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: next_state = datain ? S_1   : S_IDLE;
            S_1:    next_state = datain ? S_1   : S_10;
            S_10:   next_state = datain ? S_101 : S_IDLE;
            S_101:  next_state = datain ? S_1   : (OVERLAP ? S_10 : S_IDLE);
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs come from the registered state only, so they cannot glitch with datain.
    assign pattern_detected = (state == S_101);
    assign temp             = state;

endmodule

// File: tb/tb_pattern_detection_one_oh_one.sv
// Directed bench for the "101" detector, overlapping and non-overlapping builds side by side.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; one bit is driven per clock.
module tb_pattern_detection_one_oh_one;

    logic       clk;
    logic       rst_n;
    logic       datain;
    logic       det1;
    logic [2:0] temp1;
    logic       det0;
    logic [2:0] temp0;

    int total = 0;
    int bad   = 0;

    pattern_detection_one_oh_one #(.OVERLAP(1'b1)) dut_ov1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .datain           (datain),
        .pattern_detected (det1),
        .temp             (temp1)
    );

    pattern_detection_one_oh_one #(.OVERLAP(1'b0)) dut_ov0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .datain           (datain),
        .pattern_detected (det0),
        .temp             (temp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one bit, let one edge pass, then check both builds.
    // e1/e0 are the hand-derived states expected for OVERLAP=1 / OVERLAP=0.
    task automatic step(input string tag, input logic d,
                        input logic [2:0] e1, input logic [2:0] e0,
                        input logic x1, input logic x0);
        datain = d;
        @(posedge clk);
        #1;
        chk({tag, ".temp_ov1"}, temp1, e1);
        chk({tag, ".det_ov1"},  {2'b00, det1}, {2'b00, x1});
        chk({tag, ".temp_ov0"}, temp0, e0);
        chk({tag, ".det_ov0"},  {2'b00, det0}, {2'b00, x0});
    endtask

    // Asynchronous reset pulse placed mid-cycle, clear of any edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, ".async_ov1"}, temp1, 3'd0);
        chk({tag, ".async_ov0"}, temp0, 3'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        datain = 1'b0;

        // 1. reset held: datain toggling must not move the FSM
        for (int i = 0; i < 4; i++) begin
            datain = i[0] ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            chk("rst_hold.temp", temp1, 3'd0);
            chk("rst_hold.det",  {2'b00, det1}, 3'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("pre_async.b1", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("pre_async.b0", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        pulse_reset("t1");

        // 2/3. 1,0,1,0,1: overlap gives two pulses, non-overlap one
        step("t3.e1", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t3.e2", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        step("t3.e3", 1'b1, 3'd3, 3'd3, 1'b1, 1'b1);
        step("t3.e4", 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
        step("t3.e5", 1'b1, 3'd3, 3'd1, 1'b1, 1'b0);
        step("t3.e6", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        pulse_reset("t3");

        // 4. 1,1,1,0,0,1,0,1 then 1: run of ones, "1001" rejected, match, S_101 on '1'
        step("t4.e1", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t4.e2", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t4.e3", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t4.e4", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        step("t4.e5", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("t4.e6", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t4.e7", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        step("t4.e8", 1'b1, 3'd3, 3'd3, 1'b1, 1'b1);
        step("t4.e9", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t4.e10", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        step("t4.e11", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("t4.e12", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // 5. partial "10", reset, then '1' must not complete a match
        step("t5.e1", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t5.e2", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        pulse_reset("t5");
        step("t5.e3", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step("t5.e4", 1'b0, 3'd2, 3'd2, 1'b0, 1'b0);
        step("t5.e5", 1'b1, 3'd3, 3'd3, 1'b1, 1'b1);
        step("t5.e6", 1'b0, 3'd2, 3'd0, 1'b0, 1'b0);
        step("t5.e7", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // 6. load illegal code 5 into the overlap build, expect recovery to idle
        force dut_ov1.next_state = 3'd5;
        @(posedge clk);
        #1;
        chk("t6.illegal_temp", temp1, 3'd5);
        chk("t6.illegal_det",  {2'b00, det1}, 3'd0);
        release dut_ov1.next_state;
        datain = 1'b1;
        #1;
        datain = 1'b0;
        #1;
        @(posedge clk);
        #1;
        chk("t6.recover_temp", temp1, 3'd0);
        chk("t6.recover_det",  {2'b00, det1}, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
